relu_vec: RTL and testbench
===========================

RELU_VEC -- requirements
Module: relu_vec

Interface
REQ-001 The block SHALL have parameter N, default 32: bit-width of each share and result element.
REQ-002 The block SHALL have parameter L, default 8: elements per vector; L SHALL be a multiple of C.
REQ-003 The block SHALL have parameter C, default 2: lanes evaluated per cycle.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  input vector present.
REQ-007 in_ready  output  1  block can accept a vector.
REQ-008 g_input  input  2*N*L  garbler shares; element i: r1 at [2Ni+2N-1:2Ni+N], r2 at [2Ni+N-1:2Ni].
REQ-009 e_input  input  N*L  evaluator shares; element i (x-r1) at [Ni+N-1:Ni].
REQ-010 o  output  N*L  masked results; element i = ReLU(x_i)+r2_i at [Ni+N-1:Ni].
REQ-011 out_valid  output  1  o holds a complete result vector.
REQ-012 out_ready  input  1  consumer accepts o.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 Per element: s = r1 + e as an (N+1)-bit sum; x = s[N-1:0]; pos = s[N] (carry-out); relu_x = pos ? x : 0; o_i = (relu_x + r2) mod 2^N, with the carry discarded.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE: in_ready = 1; on in_valid, register g_input and e_input, set idx = 0, and go to RUN.
REQ-017 RUN: each cycle evaluate elements idx..idx+C-1 from registered inputs, write them into o, then set idx += C; when idx+C == L, go to DONE.
REQ-018 DONE: out_valid = 1; o SHALL remain stable until out_ready = 1, then go to IDLE in the next cycle.
REQ-019 Latency SHALL be L/C+1 cycles from the accept edge to the first cycle with out_valid = 1.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored, and changes on the input ports SHALL NOT affect the result in progress.
REQ-021 When out_ready is held high, a new vector SHALL be accepted no earlier than the cycle after the DONE-to-IDLE transition (no overlap).
REQ-022 When L == C, RUN SHALL last exactly one cycle.
REQ-023 Arithmetic wraps mod 2^N; no saturation is performed.

Reset
REQ-024 When rst = 1 at a clock edge: state = IDLE, idx = 0, o = 0, out_valid = 0, and the input registers = 0.
REQ-025 Reset in RUN or DONE SHALL abort the operation; the partial result is discarded and no out_valid pulse follows.
REQ-026 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-027 Macro RELU_VEC_SIGNED_EN: when defined, pos = ~x[N-1] (two's-complement sign test, no offset encoding); when undefined, pos = s[N] as in REQ-014.
REQ-028 The port list, latency and FSM SHALL be identical with and without RELU_VEC_SIGNED_EN.

Structure
REQ-029 Shared package relu_pkg SHALL hold the FSM state encoding (IDLE/RUN/DONE) and the element-slicing width constants.
REQ-030 Sub-module relu_lane SHALL be a combinational single-element evaluation of REQ-014/REQ-027; the block SHALL instantiate it C times.
REQ-031 The idx counter SHALL be $clog2(L)+1 bits wide.

Verification (N=8, L=4, C=2 unless stated otherwise)
REQ-032 Positive element: r1=0x10, e=0xF8, r2=0x05 -> s=0x108, pos=1, o_i = 0x0D.
REQ-033 Non-positive element: r1=0x10, e=0x20, r2=0x05 -> pos=0, o_i = 0x05; with RELU_VEC_SIGNED_EN defined -> o_i = 0x35.
REQ-034 Output wrap: r1=0xF0, e=0x20, r2=0xFF -> x=0x10, o_i = 0x0F.
REQ-035 Handshake: accept at cycle t -> out_valid rises at t+3; out_ready held low for 5 cycles -> o is stable and in_ready = 0 throughout; in_valid pulses during RUN are ignored.
REQ-036 Reset mid-RUN: rst asserted one cycle after accept -> next cycle shows state IDLE, o = 0, out_valid = 0, in_ready = 1, and no out_valid pulse follows.
REQ-037 Back-to-back: two vectors with out_ready tied high -> two results in order, each bit-exact against a software model.

Source files
------------

// File: rtl/relu_pkg.sv
// Shared definitions for the masked vector ReLU block: FSM encoding and share layout.
package relu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } relu_state_t;

    // Each garbler element holds two N-bit shares: r1 in the upper half, r2 in the lower.
    localparam int G_SHARES  = 2;
    localparam int R1_SHARE  = 1;
    localparam int R2_SHARE  = 0;

endpackage

// File: rtl/relu_lane.sv
// Combinational single-element ReLU on masked shares: o = ReLU(r1 + e) + r2 mod 2^N.
// RELU_VEC_SIGNED_EN selects a two's-complement sign test instead of the carry-out test.
module relu_lane
    import relu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] r1,
    input  logic [N-1:0] r2,
    input  logic [N-1:0] e,
    output logic [N-1:0] o
);

    logic [N-1:0] x;
    logic [N-1:0] relu_x;
    logic         pos;

    always_comb begin
`ifdef RELU_VEC_SIGNED_EN
        x   = r1 + e;
        pos = ~x[N-1];
`else
        {pos, x} = {1'b0, r1} + {1'b0, e};
`endif
        relu_x = pos ? x : '0;
        o      = relu_x + r2;
    end

endmodule

// File: rtl/relu_vec.sv
// Vector ReLU on masked shares, C lanes per cycle over L elements with a valid/ready handshake.
// Optional macro RELU_VEC_SIGNED_EN (see relu_lane) changes only the positivity test.
module relu_vec
    import relu_pkg::*;
#(
    parameter int N = 32,
    parameter int L = 8,
    parameter int C = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [G_SHARES*N*L-1:0]    g_input,
    input  logic [N*L-1:0]             e_input,
    output logic [N*L-1:0]             o,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int IW = $clog2(L) + 1;
    localparam logic [IW-1:0] STEP  = IW'(C);
    localparam logic [IW-1:0] LIMIT = IW'(L);

    relu_state_t state, next_state;

    logic [IW-1:0]           idx;
    logic [G_SHARES*N*L-1:0] g_reg;
    logic [N*L-1:0]          e_reg;
    logic                    last_step;

    int           lane_elem [C];
    logic [N-1:0] lane_r1   [C];
    logic [N-1:0] lane_r2   [C];
    logic [N-1:0] lane_e    [C];
    logic [N-1:0] lane_o    [C];

    assign last_step = ((idx + STEP) == LIMIT);

    // Element index is clamped so DONE (idx == L) never addresses past the vector.
    always_comb begin
        for (int c = 0; c < C; c++) begin
            lane_elem[c] = int'(idx) + c;
            if (lane_elem[c] >= L) begin
                lane_elem[c] = 0;
            end
            lane_r1[c] = g_reg[G_SHARES*N*lane_elem[c] + R1_SHARE*N +: N];
            lane_r2[c] = g_reg[G_SHARES*N*lane_elem[c] + R2_SHARE*N +: N];
            lane_e[c]  = e_reg[N*lane_elem[c] +: N];
        end
    end

    for (genvar c = 0; c < C; c++) begin : g_lane
        relu_lane #(.N(N)) u_lane (
            .r1 (lane_r1[c]),
            .r2 (lane_r2[c]),
            .e  (lane_e[c]),
            .o  (lane_o[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Inputs are captured only at accept, so port activity during RUN/DONE cannot disturb o.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            g_reg <= '0;
            e_reg <= '0;
            o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        g_reg <= g_input;
                        e_reg <= e_input;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int c = 0; c < C; c++) begin
                        o[N*lane_elem[c] +: N] <= lane_o[c];
                    end
                    idx <= idx + STEP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_vec.sv
// Directed self-checking bench for relu_vec with N=8, L=4, C=2.
// Expected values follow RELU_VEC_SIGNED_EN when the bench is built with it.
module tb_relu_vec;

    localparam int N = 8;
    localparam int L = 4;
    localparam int C = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2*N*L-1:0] g_input;
    logic [N*L-1:0]   e_input;
    logic [N*L-1:0]   o;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    int testsRun;
    int testsFailed;

    // Vector A: positive, non-positive, output-wrap and carry-free-negative elements.
    localparam logic [2*N*L-1:0] G_A = {8'h7F, 8'h22, 8'hF0, 8'hFF, 8'h10, 8'h05, 8'h10, 8'h05};
    localparam logic [N*L-1:0]   E_A = {8'h01, 8'h20, 8'h20, 8'hF8};
    localparam logic [2*N*L-1:0] G_B = {8'hC0, 8'hF0, 8'h00, 8'hAB, 8'hFF, 8'h00, 8'h01, 8'h10};
    localparam logic [N*L-1:0]   E_B = {8'h50, 8'h00, 8'hFF, 8'hFF};
`ifdef RELU_VEC_SIGNED_EN
    localparam logic [N*L-1:0]   EXP_A = {8'h22, 8'h0F, 8'h35, 8'h0D};
    localparam logic [N*L-1:0]   EXP_B = {8'h00, 8'hAB, 8'h00, 8'h10};
`else
    localparam logic [N*L-1:0]   EXP_A = {8'h22, 8'h0F, 8'h05, 8'h0D};
    localparam logic [N*L-1:0]   EXP_B = {8'h00, 8'hAB, 8'hFE, 8'h10};
`endif

    relu_vec #(.N(N), .L(L), .C(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .g_input   (g_input),
        .e_input   (e_input),
        .o         (o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [N*L-1:0] modelVec(input logic [2*N*L-1:0] g, input logic [N*L-1:0] e);
        logic [N*L-1:0] res;
        logic [N-1:0]   r1, r2, ev, x;
        logic [N:0]     s;
        logic           pos;
        res = '0;
        for (int i = 0; i < L; i++) begin
            r1 = g[2*N*i + N +: N];
            r2 = g[2*N*i +: N];
            ev = e[N*i +: N];
            s  = {1'b0, r1} + {1'b0, ev};
            x  = s[N-1:0];
`ifdef RELU_VEC_SIGNED_EN
            pos = ~x[N-1];
`else
            pos = s[N];
`endif
            res[N*i +: N] = (pos ? x : '0) + r2;
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents one vector for a single accept edge.
    task automatic applyStimulus(input logic [2*N*L-1:0] g, input logic [N*L-1:0] e);
        for (int i = 0; i < 20 && !in_ready; i++) begin
            stepCycle();
        end
        checkOutput("accept_ready", in_ready, 1);
        g_input  = g;
        e_input  = e;
        in_valid = 1'b1;
        stepCycle();
        in_valid = 1'b0;
    endtask

    task automatic waitForValid(input string tag);
        for (int i = 0; i < 20 && !out_valid; i++) begin
            stepCycle();
        end
        checkOutput(tag, out_valid, 1);
    endtask

    initial begin
        logic sawValid;
        testsRun    = 0;
        testsFailed = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        g_input   = '0;
        e_input   = '0;

        stepCycle();
        stepCycle();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_o", o, 0);
        checkOutput("rst_busy", busy, 0);
        rst = 1'b0;
        stepCycle();
        checkOutput("rst_in_ready", in_ready, 1);

        // Latency, stall in DONE, and ignored input activity during RUN.
        applyStimulus(G_A, E_A);
        checkOutput("run_busy", busy, 1);
        checkOutput("run_in_ready", in_ready, 0);
        checkOutput("lat_cyc1", out_valid, 0);
        g_input  = G_B;
        e_input  = E_B;
        in_valid = 1'b1;
        stepCycle();
        checkOutput("lat_cyc2", out_valid, 0);
        in_valid = 1'b0;
        stepCycle();
        checkOutput("lat_cyc3", out_valid, 1);
        checkOutput("vec_a", o, EXP_A);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("stall_o", o, EXP_A);
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        stepCycle();
        checkOutput("done_release_valid", out_valid, 0);
        checkOutput("done_release_ready", in_ready, 1);
        out_ready = 1'b0;

        // Back-to-back with out_ready tied high.
        out_ready = 1'b1;
        applyStimulus(G_A, E_A);
        waitForValid("b2b_valid_a");
        checkOutput("b2b_o_a", o, modelVec(G_A, E_A));
        checkOutput("b2b_no_overlap", in_ready, 0);
        stepCycle();
        checkOutput("b2b_idle", in_ready, 1);
        applyStimulus(G_B, E_B);
        waitForValid("b2b_valid_b");
        checkOutput("b2b_o_b_model", o, modelVec(G_B, E_B));
        checkOutput("b2b_o_b_hand", o, EXP_B);
        stepCycle();
        out_ready = 1'b0;

        // Reset one cycle after accept aborts the operation.
        applyStimulus(G_B, E_B);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("abort_valid", out_valid, 0);
        checkOutput("abort_o", o, 0);
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_busy", busy, 0);
        sawValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("abort_no_pulse", sawValid, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
